// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Package     : mem_arbiter_pkg
// Description : Shared types and constants for the unified-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Requester indices into req_in / we_in / addr_in / wdata_in
  localparam int REQ_FETCH = 0;
  localparam int REQ_DATA  = 1;
  localparam int REQ_EXT   = 2;
  localparam int NUM_REQ   = 3;

  // Width of the access latency counter (MEM_LATENCY is at most 15)
  localparam int CNT_W = 4;

  // Next requester index in round-robin order, wrapping 2 -> 0.
  // Index 3 never occurs and is folded back onto requester 0.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    logic [1:0] res;
    case (idx)
      2'd0:    res = 2'd1;
      2'd1:    res = 2'd2;
      default: res = 2'd0;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/memory_arbiter_rr_picker.sv
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin selector over three requesters.
//               Priority order is ptr, ptr+1, ptr+2 (mod 3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker
  import mem_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] winner
);

  logic [1:0] first_idx;
  logic [1:0] second_idx;
  logic [1:0] third_idx;

  // Build the priority order starting at the pointer; an out-of-range
  // pointer value behaves as requester 0.
  always_comb begin
    first_idx  = (ptr == 2'd3) ? 2'd0 : ptr;
    second_idx = next_idx(first_idx);
    third_idx  = next_idx(second_idx);
  end

  // Pick the first active request in priority order
  always_comb begin
    valid  = |req;
    winner = first_idx;
    if (req[first_idx]) begin
      winner = first_idx;
    end else if (req[second_idx]) begin
      winner = second_idx;
    end else if (req[third_idx]) begin
      winner = third_idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/memory_arbiter.sv
// ============================================================================
// Module      : memory_arbiter
// Description : Round-robin arbiter sharing one single-port memory between
//               instruction fetch, data access and an external loader port.
//               Each access is sequenced over a fixed read latency and
//               completed with a four-phase req/done handshake. All outputs
//               are registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 11,
  parameter int DATA_WIDTH  = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                        clock_in,
  input  logic                        reset_in,
  input  logic [2:0]                  req_in,
  input  logic [2:0]                  we_in,
  input  logic [3*ADDR_WIDTH-1:0]     addr_in,
  input  logic [3*DATA_WIDTH-1:0]     wdata_in,
  output logic [2:0]                  done_out,
  output logic [DATA_WIDTH-1:0]       rdata_out,
  output logic                        busy_out,
  output logic [1:0]                  grant_out,
  output logic [ADDR_WIDTH-1:0]       mem_addr_out,
  output logic [DATA_WIDTH-1:0]       mem_wdata_out,
  output logic                        mem_we_out,
  input  logic [DATA_WIDTH-1:0]       mem_rdata_in
);

  // --------------------------------------------------------------------------
  // Registered state. The latched address/write data of the owner are the
  // memory-side outputs themselves, so they stay stable for every ACCESS
  // cycle and no separate copy is needed. grant_out doubles as the owner
  // index and is cleared on return to IDLE.
  // --------------------------------------------------------------------------
  state_t                  state_r,     state_n;
  logic [1:0]              ptr_r,       ptr_n;
  logic [CNT_W-1:0]        cnt_r,       cnt_n;
  logic                    we_lat_r,    we_lat_n;
  logic [1:0]              grant_n;
  logic [2:0]              done_n;
  logic [DATA_WIDTH-1:0]   rdata_n;
  logic                    busy_n;
  logic [ADDR_WIDTH-1:0]   mem_addr_n;
  logic [DATA_WIDTH-1:0]   mem_wdata_n;
  logic                    mem_we_n;

  logic                    pick_valid;
  logic [1:0]              pick_idx;

  // Round-robin selection among current requests
  rr_picker u_rr_picker (
    .req    (req_in),
    .ptr    (ptr_r),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  // State and output registers with asynchronous reset; a write in flight
  // is simply abandoned.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_r       <= IDLE;
      ptr_r         <= 2'd0;
      cnt_r         <= '0;
      we_lat_r      <= 1'b0;
      grant_out     <= 2'd0;
      done_out      <= 3'b000;
      rdata_out     <= '0;
      busy_out      <= 1'b0;
      mem_addr_out  <= '0;
      mem_wdata_out <= '0;
      mem_we_out    <= 1'b0;
    end else begin
      state_r       <= state_n;
      ptr_r         <= ptr_n;
      cnt_r         <= cnt_n;
      we_lat_r      <= we_lat_n;
      grant_out     <= grant_n;
      done_out      <= done_n;
      rdata_out     <= rdata_n;
      busy_out      <= busy_n;
      mem_addr_out  <= mem_addr_n;
      mem_wdata_out <= mem_wdata_n;
      mem_we_out    <= mem_we_n;
    end
  end

  // Next-state and next-output logic; everything holds by default and the
  // write strobe defaults low so it can only last one ACCESS cycle.
  always_comb begin
    state_n     = state_r;
    ptr_n       = ptr_r;
    cnt_n       = cnt_r;
    we_lat_n    = we_lat_r;
    grant_n     = grant_out;
    done_n      = done_out;
    rdata_n     = rdata_out;
    busy_n      = busy_out;
    mem_addr_n  = mem_addr_out;
    mem_wdata_n = mem_wdata_out;
    mem_we_n    = 1'b0;

    case (state_r)
      IDLE: begin
        if (pick_valid) begin
          state_n     = ACCESS;
          grant_n     = pick_idx;
          we_lat_n    = we_in[pick_idx];
          mem_addr_n  = addr_in[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          mem_wdata_n = wdata_in[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
          mem_we_n    = we_in[pick_idx];
          cnt_n       = CNT_W'(MEM_LATENCY);
          busy_n      = 1'b1;
        end
      end

      ACCESS: begin
        // The last ACCESS cycle is the one where read data is valid
        if (cnt_r == '0) begin
          state_n = DONE;
          done_n  = 3'b001 << grant_out;
          if (!we_lat_r) begin
            rdata_n = mem_rdata_in;
          end
        end else begin
          cnt_n = cnt_r - 1'b1;
        end
      end

      DONE: begin
        // Hold completion until the owner withdraws its request
        if (!req_in[grant_out]) begin
          state_n = IDLE;
          ptr_n   = next_idx(grant_out);
          grant_n = 2'd0;
          done_n  = 3'b000;
          busy_n  = 1'b0;
        end
      end

      default: begin
        state_n = IDLE;
        grant_n = 2'd0;
        done_n  = 3'b000;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire
